operand_packer: RTL and testbench
=================================

OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 Parameter BIT_WIDTH, default 18: width of one signed fixed-point element.
REQ-002 Parameter N, default 4: elements per packed vector; a power of two, 2 or more.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 s_valid  input  1  an input element pair is offered.
REQ-006 s_ready  output  1  the block accepts the offered pair this cycle.
REQ-007 s_a  input  BIT_WIDTH  element of operand A.
REQ-008 s_b  input  BIT_WIDTH  element of operand B.
REQ-009 s_last  input  1  this pair closes the current vector.
REQ-010 m_valid  output  1  a packed vector pair is presented.
REQ-011 m_ready  input  1  the downstream multiply-add tree accepts the presented vectors.
REQ-012 m_a  output  BIT_WIDTH*N  packed A vector; lane k is bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
REQ-013 m_b  output  BIT_WIDTH*N  packed B vector, with the same lane mapping as m_a.
REQ-014 vec_cnt  output  16  count of vectors emitted.

Function
REQ-015 An input beat is accepted when s_valid=1 and s_ready=1.
REQ-016 An output beat is accepted when m_valid=1 and m_ready=1.
REQ-017 The first accepted element of a vector goes to lane 0; each following element goes to the next lane.
REQ-018 A lane index counter (0..N-1) selects the target lane in the assembly registers.
REQ-019 A vector completes on an accepted beat at lane N-1, or on an accepted beat with s_last=1, whichever comes first.
REQ-020 On a short vector (s_last=1 at lane k<N-1), lanes k+1..N-1 of both m_a and m_b shall be zero.
REQ-021 Storage is one assembly register pair, one output register pair, and a pend flag.
REQ-022 On the completing beat, the vector moves into the output register at the same edge if the output register is free (m_valid=0, or an output beat occurs that cycle). m_valid=1 from the next cycle.
REQ-023 If the output register is not free on the completing beat, set pend=1 and hold the vector in the assembly register.
REQ-024 s_ready = !pend, combinational from the registered flag.
REQ-025 While pend=1: on the first output beat, the pending vector moves into the output register, pend clears, the lane index returns to 0, and m_valid stays 1.
REQ-026 The lane index returns to 0 after every completing beat.
REQ-027 Assembly lanes are cleared to zero when each new vector starts.
REQ-028 If an output beat occurs with no replacement vector available, m_valid falls on the next cycle.
REQ-029 m_a and m_b shall stay stable while m_valid=1 and m_ready=0.
REQ-030 vec_cnt increments by 1 per output beat and wraps from 65535 to 0.
REQ-031 Sustained throughput with m_ready held at 1 is one full vector every N input cycles, with no bubbles.
REQ-032 Data passes through bit-exact; no arithmetic is applied.

Reset
REQ-033 While rst=1: m_valid=0, m_a=0, m_b=0, vec_cnt=0, pend=0, lane index=0, assembly registers=0.
REQ-034 s_ready is 1 on the first cycle after reset deasserts.
REQ-035 Reset asserted mid-vector discards the partial vector and any pending or presented vector; nothing partial is emitted afterwards.

Structure
REQ-036 A shared package holds the defaults BIT_WIDTH=18, N=4 and the vec_cnt width constant 16.
REQ-037 The lane index width is $clog2(N), derived locally.
REQ-038 One sub-module, packer_lane_reg, holds one lane register with its load-enable and clear-enable; it is instantiated N times per operand.

Verification
REQ-039 Full vector: with m_ready=1, send a=1,2,3,4 and b=5,6,7,8 on consecutive cycles. Response: m_valid=1 on the cycle after a=4, with m_a lanes 0..3 = 1,2,3,4 and m_b lanes 0..3 = 5,6,7,8; vec_cnt=1 after the output beat.
REQ-040 Short vector: send a=9, 10 with s_last=1 on the second beat. Response: m_a lanes = 9,10,0,0; the next vector starts at lane 0.
REQ-041 Backpressure: hold m_ready=0 and send 8 beats. Response: the first vector is held stable, pend=1 after beat 8, and s_ready=0. Raising m_ready for one cycle outputs vector 1; vector 2 is presented the next cycle and s_ready returns to 1.
REQ-042 Streaming: with m_ready=1, send 64 beats back-to-back. Response: 16 vectors emitted, no s_ready deassertion, vec_cnt=16.
REQ-043 Reset mid-vector: send 2 beats, pulse rst for 1 cycle, then send 4 beats of 7. Response: the single emitted vector has m_a lanes = 7,7,7,7.
REQ-044 Wrap: preload the count to 65535 (or emit 65536 vectors). Response: vec_cnt reads 0 after the next output beat.

Source files
------------

// File: rtl/operand_packer_pkg.sv
// Shared defaults for the operand packer: element width, lanes per vector and
// the width of the emitted-vector counter.
package operand_packer_pkg;

  localparam int DEF_BIT_WIDTH = 18;
  localparam int DEF_N         = 4;
  localparam int VEC_CNT_W     = 16;

endpackage

// File: rtl/operand_packer_if.sv
// Element-stream input and packed-vector output of the operand packer.
// The slave modport is the packer's view; master is the surrounding logic.
interface operand_packer_if
  import operand_packer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N
);

  logic                        s_valid;
  logic                        s_ready;
  logic signed [BIT_WIDTH-1:0] s_a;
  logic signed [BIT_WIDTH-1:0] s_b;
  logic                        s_last;
  logic                        m_valid;
  logic                        m_ready;
  logic [BIT_WIDTH*N-1:0]      m_a;
  logic [BIT_WIDTH*N-1:0]      m_b;
  logic [VEC_CNT_W-1:0]        vec_cnt;

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_a, m_b, vec_cnt
  );

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_a, m_b, vec_cnt
  );

endinterface

// File: rtl/operand_packer_lane_reg.sv
// One assembly lane: load wins over clear, so the first element of a new
// vector can be written while the remaining lanes are zeroed.
module packer_lane_reg #(
  parameter int BIT_WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld,
  input  logic                        clr,
  input  logic signed [BIT_WIDTH-1:0] d,
  output logic signed [BIT_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/operand_packer.sv
// Packs a stream of (a, b) element pairs into N-lane vector pairs for a
// multiply-add tree; one assembly stage (p0) feeds one output stage (p1).
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N
) (
  input  logic             clk,
  input  logic             rst,
  operand_packer_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N - 1);

  logic [IDX_W-1:0]            lane_idx_p0;
  logic                        pend_p0;
  logic signed [BIT_WIDTH-1:0] asm_a_p0 [N];
  logic signed [BIT_WIDTH-1:0] asm_b_p0 [N];

  logic [BIT_WIDTH*N-1:0]      a_p1;
  logic [BIT_WIDTH*N-1:0]      b_p1;
  logic                        vld_p1;
  logic [VEC_CNT_W-1:0]        vec_cnt_p1;

  logic                        in_fire;
  logic                        out_fire;
  logic                        out_free;
  logic                        complete;
  logic                        start;
  logic                        release_pend;
  logic [BIT_WIDTH*N-1:0]      nxt_a_pk;
  logic [BIT_WIDTH*N-1:0]      nxt_b_pk;
  logic [BIT_WIDTH*N-1:0]      asm_a_pk;
  logic [BIT_WIDTH*N-1:0]      asm_b_pk;

  assign in_fire      = bus.s_valid && !pend_p0;
  assign out_fire     = vld_p1 && bus.m_ready;
  assign out_free     = !vld_p1 || bus.m_ready;
  assign complete     = in_fire && (bus.s_last || (lane_idx_p0 == LAST_LANE));
  assign start        = in_fire && (lane_idx_p0 == '0);
  assign release_pend = pend_p0 && bus.m_ready;

  // ---- stage p0: lane assembly ----
  for (genvar k = 0; k < N; k++) begin : g_lane
    packer_lane_reg #(.BIT_WIDTH(BIT_WIDTH)) u_lane_a (
      .clk (clk),
      .rst (rst),
      .ld  (in_fire && (lane_idx_p0 == IDX_W'(k))),
      .clr (start),
      .d   (bus.s_a),
      .q   (asm_a_p0[k])
    );
    packer_lane_reg #(.BIT_WIDTH(BIT_WIDTH)) u_lane_b (
      .clk (clk),
      .rst (rst),
      .ld  (in_fire && (lane_idx_p0 == IDX_W'(k))),
      .clr (start),
      .d   (bus.s_b),
      .q   (asm_b_p0[k])
    );
  end

  // Vector as it stands after the current beat; lanes beyond it are zero even
  // when the assembly registers still hold the previous vector.
  always_comb begin
    nxt_a_pk = '0;
    nxt_b_pk = '0;
    asm_a_pk = '0;
    asm_b_pk = '0;
    for (int k = 0; k < N; k++) begin
      asm_a_pk[k*BIT_WIDTH +: BIT_WIDTH] = asm_a_p0[k];
      asm_b_pk[k*BIT_WIDTH +: BIT_WIDTH] = asm_b_p0[k];
      if (IDX_W'(k) == lane_idx_p0) begin
        nxt_a_pk[k*BIT_WIDTH +: BIT_WIDTH] = bus.s_a;
        nxt_b_pk[k*BIT_WIDTH +: BIT_WIDTH] = bus.s_b;
      end else if (IDX_W'(k) < lane_idx_p0) begin
        nxt_a_pk[k*BIT_WIDTH +: BIT_WIDTH] = asm_a_p0[k];
        nxt_b_pk[k*BIT_WIDTH +: BIT_WIDTH] = asm_b_p0[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx_p0 <= '0;
      pend_p0     <= 1'b0;
    end else begin
      if (in_fire) begin
        lane_idx_p0 <= complete ? '0 : lane_idx_p0 + IDX_W'(1);
      end else if (release_pend) begin
        lane_idx_p0 <= '0;
      end
      if (complete && !out_free) begin
        pend_p0 <= 1'b1;
      end else if (release_pend) begin
        pend_p0 <= 1'b0;
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1       <= '0;
      b_p1       <= '0;
      vld_p1     <= 1'b0;
      vec_cnt_p1 <= '0;
    end else begin
      if (out_fire) begin
        vec_cnt_p1 <= vec_cnt_p1 + VEC_CNT_W'(1);
      end
      if (complete && out_free) begin
        a_p1   <= nxt_a_pk;
        b_p1   <= nxt_b_pk;
        vld_p1 <= 1'b1;
      end else if (release_pend) begin
        a_p1   <= asm_a_pk;
        b_p1   <= asm_b_pk;
        vld_p1 <= 1'b1;
      end else if (out_fire) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.s_ready = !pend_p0;
  assign bus.m_valid = vld_p1;
  assign bus.m_a     = a_p1;
  assign bus.m_b     = b_p1;
  assign bus.vec_cnt = vec_cnt_p1;

endmodule

// File: tb/tb_operand_packer.sv
// Directed-vector bench for operand_packer with BIT_WIDTH=18, N=4.
module tb_operand_packer;

  localparam int W  = 18;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  operand_packer_if #(.BIT_WIDTH(W), .N(NL)) bus ();

  operand_packer #(.BIT_WIDTH(W), .N(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [W*NL-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {18'(a3), 18'(a2), 18'(a1), 18'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b, input logic last);
    bus.s_valid = 1'b1;
    bus.s_a     = 18'(a);
    bus.s_b     = 18'(b);
    bus.s_last  = last;
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    step(); step();
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %0b want 0", bus.m_valid); end
    n_checks++; if (bus.m_a !== '0 || bus.m_b !== '0) begin n_fail++; $display("FAIL rst_data got %h/%h want 0", bus.m_a, bus.m_b); end
    n_checks++; if (bus.vec_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_vec_cnt got %0d want 0", bus.vec_cnt); end
    rst = 1'b0;
    step();
    n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_full_vector();
    bus.m_ready = 1'b1;
    beat(1, 5, 1'b0); beat(2, 6, 1'b0); beat(3, 7, 1'b0);
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %0b want 0", bus.m_valid); end
    beat(4, 8, 1'b0);
    n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %0b want 1", bus.m_valid); end
    n_checks++; if (bus.m_a !== pk(1, 2, 3, 4)) begin n_fail++; $display("FAIL full_m_a got %h want %h", bus.m_a, pk(1, 2, 3, 4)); end
    n_checks++; if (bus.m_b !== pk(5, 6, 7, 8)) begin n_fail++; $display("FAIL full_m_b got %h want %h", bus.m_b, pk(5, 6, 7, 8)); end
    step();
    exp_cnt = 1;
    n_checks++; if (bus.vec_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL full_vec_cnt got %0d want %0d", bus.vec_cnt, exp_cnt); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_drop got %0b want 0", bus.m_valid); end
  endtask

  task automatic test_short_vector();
    bus.m_ready = 1'b1;
    beat(9, 1, 1'b0); beat(10, 2, 1'b1);
    n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid got %0b want 1", bus.m_valid); end
    n_checks++; if (bus.m_a !== pk(9, 10, 0, 0)) begin n_fail++; $display("FAIL short_m_a got %h want %h", bus.m_a, pk(9, 10, 0, 0)); end
    n_checks++; if (bus.m_b !== pk(1, 2, 0, 0)) begin n_fail++; $display("FAIL short_m_b got %h want %h", bus.m_b, pk(1, 2, 0, 0)); end
    // next vector must restart at lane 0; includes a negative element
    beat(11, 3, 1'b0); beat(-3, 4, 1'b0); beat(13, 5, 1'b0); beat(14, -6, 1'b0);
    exp_cnt = 2;
    n_checks++; if (bus.m_a !== pk(11, -3, 13, 14)) begin n_fail++; $display("FAIL short_next_m_a got %h want %h", bus.m_a, pk(11, -3, 13, 14)); end
    n_checks++; if (bus.m_b !== pk(3, 4, 5, -6)) begin n_fail++; $display("FAIL short_next_m_b got %h want %h", bus.m_b, pk(3, 4, 5, -6)); end
    step();
    exp_cnt = 3;
    n_checks++; if (bus.vec_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL short_vec_cnt got %0d want %0d", bus.vec_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int stall = 0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.s_ready !== 1'b1) stall++;
      beat(21 + i, 31 + i, 1'b0);
    end
    n_checks++; if (stall !== 0) begin n_fail++; $display("FAIL bp_early_stall got %0d want 0", stall); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready got %0b want 0", bus.s_ready); end
    step();
    n_checks++; if (bus.m_valid !== 1'b1 || bus.m_a !== pk(21, 22, 23, 24)) begin n_fail++; $display("FAIL bp_hold got %0b/%h want 1/%h", bus.m_valid, bus.m_a, pk(21, 22, 23, 24)); end
    n_checks++; if (bus.m_b !== pk(31, 32, 33, 34)) begin n_fail++; $display("FAIL bp_hold_b got %h want %h", bus.m_b, pk(31, 32, 33, 34)); end
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    exp_cnt = 4;
    n_checks++; if (bus.m_valid !== 1'b1 || bus.m_a !== pk(25, 26, 27, 28)) begin n_fail++; $display("FAIL bp_v2 got %0b/%h want 1/%h", bus.m_valid, bus.m_a, pk(25, 26, 27, 28)); end
    n_checks++; if (bus.m_b !== pk(35, 36, 37, 38)) begin n_fail++; $display("FAIL bp_v2_b got %h want %h", bus.m_b, pk(35, 36, 37, 38)); end
    n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_s_ready_back got %0b want 1", bus.s_ready); end
    n_checks++; if (bus.vec_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_vec_cnt got %0d want %0d", bus.vec_cnt, exp_cnt); end
    bus.m_ready = 1'b1;
    step();
    exp_cnt = 5;
    n_checks++; if (bus.m_valid !== 1'b0 || bus.vec_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_drain got %0b/%0d want 0/%0d", bus.m_valid, bus.vec_cnt, exp_cnt); end
  endtask

  task automatic test_streaming();
    int stall = 0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.s_ready !== 1'b1) stall++;
      bus.s_valid = 1'b1; bus.s_a = 18'(i); bus.s_b = 18'(100 + i); bus.s_last = 1'b0;
      step();
      if (i % 4 == 3) begin
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_a !== pk(i - 3, i - 2, i - 1, i) || bus.m_b !== pk(97 + i, 98 + i, 99 + i, 100 + i)) begin
          n_fail++; $display("FAIL stream_vec%0d got %0b/%h/%h want 1/%h/%h", i / 4, bus.m_valid, bus.m_a, bus.m_b, pk(i - 3, i - 2, i - 1, i), pk(97 + i, 98 + i, 99 + i, 100 + i));
        end
      end
    end
    bus.s_valid = 1'b0;
    step();
    exp_cnt = 21;
    n_checks++; if (stall !== 0) begin n_fail++; $display("FAIL stream_stall got %0d want 0", stall); end
    n_checks++; if (bus.vec_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stream_vec_cnt got %0d want %0d", bus.vec_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_vector();
    bus.m_ready = 1'b1;
    beat(50, 60, 1'b0); beat(51, 61, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    n_checks++; if (bus.m_valid !== 1'b0 || bus.vec_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst got %0b/%0d want 0/0", bus.m_valid, bus.vec_cnt); end
    beat(7, 7, 1'b0); beat(7, 7, 1'b0); beat(7, 7, 1'b0);
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_valid got %0b want 0", bus.m_valid); end
    beat(7, 7, 1'b0);
    n_checks++; if (bus.m_valid !== 1'b1 || bus.m_a !== pk(7, 7, 7, 7)) begin n_fail++; $display("FAIL mid_vec got %0b/%h want 1/%h", bus.m_valid, bus.m_a, pk(7, 7, 7, 7)); end
    step();
    exp_cnt = 1;
    n_checks++; if (bus.vec_cnt !== 16'(exp_cnt) || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_vec_cnt got %0d/%0b want %0d/0", bus.vec_cnt, bus.m_valid, exp_cnt); end
  endtask

  task automatic test_wrap();
    bus.m_ready = 1'b1;
    // single-beat vectors: upper lanes must be zero despite stale assembly data
    beat(5, 6, 1'b1);
    n_checks++; if (bus.m_a !== pk(5, 0, 0, 0) || bus.m_b !== pk(6, 0, 0, 0)) begin n_fail++; $display("FAIL one_beat got %h/%h want %h/%h", bus.m_a, bus.m_b, pk(5, 0, 0, 0), pk(6, 0, 0, 0)); end
    bus.s_valid = 1'b1; bus.s_last = 1'b1;
    for (int i = exp_cnt + 1; i < 65535; i++) begin
      bus.s_a = 18'(i); bus.s_b = 18'(i);
      step();
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    step();
    n_checks++; if (bus.vec_cnt !== 16'd65535) begin n_fail++; $display("FAIL wrap_pre got %0d want 65535", bus.vec_cnt); end
    beat(1, 1, 1'b1);
    step();
    n_checks++; if (bus.vec_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap got %0d want 0", bus.vec_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_short_vector();
    test_backpressure();
    test_streaming();
    test_reset_mid_vector();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
